// File: rtl/control_unit_risc_if.sv
`default_nettype none
// ============================================================================
// Module   : control_unit_risc_if
// Purpose  : Control bundle between the RISC-SPM sequencer and its datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface control_unit_risc_if #(
    parameter int WORD_SIZE = 8,
    parameter int OP_SIZE   = 4
);
    logic [WORD_SIZE-1:0] instruction;
    logic                 zero;
    logic [3:0]           load_reg;
    logic                 load_pc;
    logic                 inc_pc;
    logic                 load_ir;
    logic                 load_add_r;
    logic                 load_reg_y;
    logic                 load_reg_z;
    logic [2:0]           sel_bus_1;
    logic [1:0]           sel_bus_2;
    logic                 write;
    logic [OP_SIZE-1:0]   alu_select;
    logic                 halted;

    // master = sequencer, slave = datapath
    modport master (
        input  instruction, zero,
        output load_reg, load_pc, inc_pc, load_ir, load_add_r, load_reg_y,
               load_reg_z, sel_bus_1, sel_bus_2, write, alu_select, halted
    );

    modport slave (
        output instruction, zero,
        input  load_reg, load_pc, inc_pc, load_ir, load_add_r, load_reg_y,
               load_reg_z, sel_bus_1, sel_bus_2, write, alu_select, halted
    );
endinterface
`default_nettype wire

// File: rtl/control_unit_risc.sv
`default_nettype none
// ============================================================================
// Module   : control_unit_risc
// Purpose  : Multi-cycle fetch/decode/execute sequencer for the RISC-SPM datapath.
// Revision : 1.0 - initial release
// ============================================================================
module control_unit_risc #(
    parameter int WORD_SIZE  = 8,
    parameter int OP_SIZE    = 4,
    parameter int STATE_SIZE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    control_unit_risc_if.master  bus
);

    typedef enum logic [STATE_SIZE-1:0] {
        S_IDLE = STATE_SIZE'(0),
        S_FET1 = STATE_SIZE'(1),
        S_FET2 = STATE_SIZE'(2),
        S_DEC  = STATE_SIZE'(3),
        S_EX1  = STATE_SIZE'(4),
        S_RD1  = STATE_SIZE'(5),
        S_RD2  = STATE_SIZE'(6),
        S_WR1  = STATE_SIZE'(7),
        S_WR2  = STATE_SIZE'(8),
        S_BR1  = STATE_SIZE'(9),
        S_BR2  = STATE_SIZE'(10),
        S_HALT = STATE_SIZE'(11)
    } state_t;

    localparam logic [OP_SIZE-1:0] c_op_nop = OP_SIZE'(0);
    localparam logic [OP_SIZE-1:0] c_op_add = OP_SIZE'(1);
    localparam logic [OP_SIZE-1:0] c_op_sub = OP_SIZE'(2);
    localparam logic [OP_SIZE-1:0] c_op_and = OP_SIZE'(3);
    localparam logic [OP_SIZE-1:0] c_op_not = OP_SIZE'(4);
    localparam logic [OP_SIZE-1:0] c_op_rd  = OP_SIZE'(5);
    localparam logic [OP_SIZE-1:0] c_op_wr  = OP_SIZE'(6);
    localparam logic [OP_SIZE-1:0] c_op_br  = OP_SIZE'(7);
    localparam logic [OP_SIZE-1:0] c_op_brz = OP_SIZE'(8);

    localparam logic [2:0] c_bus1_pc  = 3'd4;
    localparam logic [1:0] c_bus2_alu = 2'd0;
    localparam logic [1:0] c_bus2_b1  = 2'd1;
    localparam logic [1:0] c_bus2_mem = 2'd2;

    state_t             r_state;
    state_t             w_next_state;
    logic [OP_SIZE-1:0] w_opcode;
    logic [1:0]         w_src;
    logic [1:0]         w_dest;

    assign w_opcode = bus.instruction[WORD_SIZE-1 -: OP_SIZE];
    assign w_src    = bus.instruction[3:2];
    assign w_dest   = bus.instruction[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Outputs decode straight from state so an async reset clears them without a clock.
    always_comb begin
        w_next_state   = r_state;
        bus.load_reg   = '0;
        bus.load_pc    = 1'b0;
        bus.inc_pc     = 1'b0;
        bus.load_ir    = 1'b0;
        bus.load_add_r = 1'b0;
        bus.load_reg_y = 1'b0;
        bus.load_reg_z = 1'b0;
        bus.sel_bus_1  = '0;
        bus.sel_bus_2  = '0;
        bus.write      = 1'b0;
        bus.alu_select = '0;
        bus.halted     = 1'b0;

        case (r_state)
            S_IDLE: w_next_state = S_FET1;
            S_FET1: begin
                bus.sel_bus_1  = c_bus1_pc;
                bus.sel_bus_2  = c_bus2_b1;
                bus.load_add_r = 1'b1;
                w_next_state   = S_FET2;
            end
            S_FET2: begin
                bus.sel_bus_2 = c_bus2_mem;
                bus.load_ir   = 1'b1;
                bus.inc_pc    = 1'b1;
                w_next_state  = S_DEC;
            end
            S_DEC: begin
                case (w_opcode)
                    c_op_nop: w_next_state = S_FET1;
                    c_op_add, c_op_sub, c_op_and: begin
                        bus.sel_bus_1  = {1'b0, w_src};
                        bus.sel_bus_2  = c_bus2_b1;
                        bus.load_reg_y = 1'b1;
                        w_next_state   = S_EX1;
                    end
                    c_op_not: begin
                        bus.sel_bus_1  = {1'b0, w_src};
                        bus.alu_select = c_op_not;
                        bus.sel_bus_2  = c_bus2_alu;
                        bus.load_reg   = 4'b0001 << w_dest;
                        bus.load_reg_z = 1'b1;
                        w_next_state   = S_FET1;
                    end
                    c_op_rd, c_op_wr, c_op_br, c_op_brz: begin
                        if (w_opcode == c_op_brz && !bus.zero) begin
                            // Untaken branch: step the PC over the address byte.
                            bus.inc_pc   = 1'b1;
                            w_next_state = S_FET1;
                        end else begin
                            bus.sel_bus_1  = c_bus1_pc;
                            bus.sel_bus_2  = c_bus2_b1;
                            bus.load_add_r = 1'b1;
                            if (w_opcode == c_op_rd) begin
                                w_next_state = S_RD1;
                            end else if (w_opcode == c_op_wr) begin
                                w_next_state = S_WR1;
                            end else begin
                                w_next_state = S_BR1;
                            end
                        end
                    end
                    default: w_next_state = S_HALT;
                endcase
            end
            S_EX1: begin
                bus.sel_bus_1  = {1'b0, w_dest};
                bus.alu_select = w_opcode;
                bus.sel_bus_2  = c_bus2_alu;
                bus.load_reg   = 4'b0001 << w_dest;
                bus.load_reg_z = 1'b1;
                w_next_state   = S_FET1;
            end
            S_RD1, S_WR1: begin
                bus.sel_bus_2  = c_bus2_mem;
                bus.load_add_r = 1'b1;
                bus.inc_pc     = 1'b1;
                w_next_state   = (r_state == S_RD1) ? S_RD2 : S_WR2;
            end
            S_RD2: begin
                bus.sel_bus_2 = c_bus2_mem;
                bus.load_reg  = 4'b0001 << w_dest;
                w_next_state  = S_FET1;
            end
            S_WR2: begin
                bus.sel_bus_1 = {1'b0, w_src};
                bus.write     = 1'b1;
                w_next_state  = S_FET1;
            end
            S_BR1: begin
                bus.sel_bus_2  = c_bus2_mem;
                bus.load_add_r = 1'b1;
                w_next_state   = S_BR2;
            end
            S_BR2: begin
                bus.sel_bus_2 = c_bus2_mem;
                bus.load_pc   = 1'b1;
                w_next_state  = S_FET1;
            end
            S_HALT: begin
                bus.halted   = 1'b1;
                w_next_state = S_HALT;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_unit_risc.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit_risc
// Purpose  : Directed scoreboard bench for the RISC-SPM control sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_unit_risc;

    typedef struct packed {
        logic [3:0] load_reg;
        logic       load_pc;
        logic       inc_pc;
        logic       load_ir;
        logic       load_add_r;
        logic       load_reg_y;
        logic       load_reg_z;
        logic [2:0] sel_bus_1;
        logic [1:0] sel_bus_2;
        logic       write;
        logic [3:0] alu_select;
        logic       halted;
    } out_t;

    typedef struct {
        string tag;
        out_t  exp;
    } sb_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    sb_t  sb_q[$];

    control_unit_risc_if bus ();

    control_unit_risc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk(logic [3:0] lr, logic lpc, logic ipc, logic lir,
                                logic lar, logic lry, logic lrz, logic [2:0] sb1,
                                logic [1:0] sb2, logic wr, logic [3:0] alu, logic h);
        return {lr, lpc, ipc, lir, lar, lry, lrz, sb1, sb2, wr, alu, h};
    endfunction

    function automatic out_t observed();
        return {bus.load_reg, bus.load_pc, bus.inc_pc, bus.load_ir, bus.load_add_r,
                bus.load_reg_y, bus.load_reg_z, bus.sel_bus_1, bus.sel_bus_2,
                bus.write, bus.alu_select, bus.halted};
    endfunction

    // Expectation templates for the recurring states
    function automatic out_t e_none();  return '0; endfunction
    function automatic out_t e_fet1();  return mk(4'b0, 0, 0, 0, 1, 0, 0, 3'd4, 2'd1, 0, 4'd0, 0); endfunction
    function automatic out_t e_fet2();  return mk(4'b0, 0, 1, 1, 0, 0, 0, 3'd0, 2'd2, 0, 4'd0, 0); endfunction
    function automatic out_t e_addr();  return e_fet1(); endfunction
    function automatic out_t e_halt();  return mk(4'b0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0, 4'd0, 1); endfunction

    task automatic pop_check();
        sb_t  item;
        out_t obs;
        obs  = observed();
        item = sb_q.pop_front();
        checks++;
        assert (obs === item.exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", item.tag, obs, item.exp);
        end
    endtask

    // Expect for the current state: compare at the falling edge, then advance one clock.
    task automatic cyc(input string tag, input out_t e);
        sb_q.push_back('{tag: tag, exp: e});
        @(negedge clk);
        pop_check();
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string tag, input out_t e);
        sb_q.push_back('{tag: tag, exp: e});
        #1;
        pop_check();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b0;
        bus.instruction = 8'h00;
        bus.zero        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_now("reset_low", e_none());

        // NOP round trip out of reset
        rst_n = 1'b1;
        cyc("idle", e_none());
        cyc("nop_fet1", e_fet1());
        cyc("nop_fet2", e_fet2());
        cyc("nop_dec", e_none());

        // ADD R1,R2
        bus.instruction = 8'h16;
        cyc("add_fet1", e_fet1());
        cyc("add_fet2", e_fet2());
        cyc("add_dec", mk(4'b0, 0, 0, 0, 0, 1, 0, 3'd1, 2'd1, 0, 4'd0, 0));
        cyc("add_ex1", mk(4'b0100, 0, 0, 0, 0, 0, 1, 3'd2, 2'd0, 0, 4'd1, 0));

        // SUB src=R3 dest=R1
        bus.instruction = 8'h2D;
        cyc("sub_fet1", e_fet1());
        cyc("sub_fet2", e_fet2());
        cyc("sub_dec", mk(4'b0, 0, 0, 0, 0, 1, 0, 3'd3, 2'd1, 0, 4'd0, 0));
        cyc("sub_ex1", mk(4'b0010, 0, 0, 0, 0, 0, 1, 3'd1, 2'd0, 0, 4'd2, 0));

        // NOT src=R2 dest=R3 completes in DEC
        bus.instruction = 8'h4B;
        cyc("not_fet1", e_fet1());
        cyc("not_fet2", e_fet2());
        cyc("not_dec", mk(4'b1000, 0, 0, 0, 0, 0, 1, 3'd2, 2'd0, 0, 4'd4, 0));

        // BRZ not taken, then taken
        bus.instruction = 8'h80;
        bus.zero        = 1'b0;
        cyc("brz0_fet1", e_fet1());
        cyc("brz0_fet2", e_fet2());
        cyc("brz0_dec", mk(4'b0, 0, 1, 0, 0, 0, 0, 3'd0, 2'd0, 0, 4'd0, 0));
        bus.zero = 1'b1;
        cyc("brz1_fet1", e_fet1());
        cyc("brz1_fet2", e_fet2());
        cyc("brz1_dec", e_addr());
        cyc("brz1_br1", mk(4'b0, 0, 0, 0, 1, 0, 0, 3'd0, 2'd2, 0, 4'd0, 0));
        cyc("brz1_br2", mk(4'b0, 1, 0, 0, 0, 0, 0, 3'd0, 2'd2, 0, 4'd0, 0));
        bus.zero = 1'b0;

        // WR src=R1
        bus.instruction = 8'h64;
        cyc("wr_fet1", e_fet1());
        cyc("wr_fet2", e_fet2());
        cyc("wr_dec", e_addr());
        cyc("wr_wr1", mk(4'b0, 0, 1, 0, 1, 0, 0, 3'd0, 2'd2, 0, 4'd0, 0));
        cyc("wr_wr2", mk(4'b0, 0, 0, 0, 0, 0, 0, 3'd1, 2'd0, 1, 4'd0, 0));

        // RD dest=R3
        bus.instruction = 8'h53;
        cyc("rd_fet1", e_fet1());
        cyc("rd_fet2", e_fet2());
        cyc("rd_dec", e_addr());
        cyc("rd_rd1", mk(4'b0, 0, 1, 0, 1, 0, 0, 3'd0, 2'd2, 0, 4'd0, 0));
        cyc("rd_rd2", mk(4'b1000, 0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 0, 4'd0, 0));

        // Illegal opcode halts until reset
        bus.instruction = 8'hF0;
        cyc("halt_fet1", e_fet1());
        cyc("halt_fet2", e_fet2());
        cyc("halt_dec", e_none());
        for (int i = 0; i < 20; i++) begin
            cyc("halt_hold", e_halt());
        end
        rst_n = 1'b0;
        #1;
        check_now("halt_reset", e_none());
        rst_n = 1'b1;
        bus.instruction = 8'h16;
        cyc("halt_idle", e_none());
        cyc("restart_fet1", e_fet1());
        cyc("restart_fet2", e_fet2());
        cyc("restart_dec", mk(4'b0, 0, 0, 0, 0, 1, 0, 3'd1, 2'd1, 0, 4'd0, 0));

        // Asynchronous reset in the middle of EX1
        check_now("async_ex1", mk(4'b0100, 0, 0, 0, 0, 0, 1, 3'd2, 2'd0, 0, 4'd1, 0));
        rst_n = 1'b0;
        check_now("async_reset", e_none());
        rst_n = 1'b1;
        #1;
        cyc("async_idle", e_none());
        cyc("async_fet1", e_fet1());
        cyc("async_fet2", e_fet2());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
